i_rotary_encoder: RTL and testbench
===================================

I_ROTARY_ENCODER -- requirements
Module: i_rotary_encoder

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning the number of flip-flop synchronizer stages per phase input (minimum 2).
REQ-002 SHALL have port i_clk, input, 1, the single clock; all logic is rising-edge triggered.
REQ-003 SHALL have port i_rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port i_phase_a, input, 1, encoder phase A, asynchronous to i_clk.
REQ-005 SHALL have port i_phase_b, input, 1, encoder phase B, asynchronous to i_clk.
REQ-006 SHALL have port o_cnt, output, 1, one-cycle pulse per completed detent.
REQ-007 SHALL have port o_cnt_cw, output, 1, direction of the last detent (1 = clockwise, 0 = counterclockwise).

Function
REQ-008 SHALL synchronize each phase through SYNC_STAGES flip-flops; all decoding uses synchronized values only. Phase pair notation is {B,A}.
REQ-009 SHALL decode with an FSM of states IDLE, CW1, CW2, CW3, CCW1, CCW2, CCW3, INVALID.
REQ-010 SHALL use these FSM transitions; any unlisted input holds the current state:
- IDLE: 01->CW1; 10->CCW1; 11->INVALID.
- CW1: 11->CW2; 10->CW3 (short cycle); 00->IDLE (no count).
- CW2: 10->CW3; 01->CW1; 00->IDLE (no count).
- CW3: 00->IDLE and emit clockwise detent; 11->CW2; 01->INVALID.
- CCW1: 11->CCW2; 01->CCW3 (short cycle); 00->IDLE (no count).
- CCW2: 01->CCW3; 10->CCW1; 00->IDLE (no count).
- CCW3: 00->IDLE and emit counterclockwise detent; 11->CCW2; 10->INVALID.
- INVALID: 00->IDLE (no count).
REQ-011 SHALL emit a detent only on the CW3->IDLE or CCW3->IDLE transitions; every other return to 00 produces no pulse.
REQ-012 SHALL register o_cnt high for exactly one i_clk cycle per detent.
REQ-013 SHALL register o_cnt_cw in the same cycle o_cnt rises and SHALL hold o_cnt_cw unchanged at all other times; it never toggles without a pulse.
REQ-014 SHALL assert o_cnt on the (SYNC_STAGES+2)-th rising i_clk edge after the edge at which the final 00 is first present on the inputs (4 edges with the default).
REQ-015 SHALL handle phase changes as fast as one per i_clk cycle without losing a detent.
REQ-016 SHALL produce at most one pulse per detent regardless of how long the phases dwell in any state.

Reset
REQ-017 SHALL, while i_rst is high at a rising edge, clear the synchronizers to 00, set the FSM to IDLE, and drive o_cnt=0 and o_cnt_cw=0.
REQ-018 SHALL discard any partial sequence on reset mid-rotation, with no pulse emitted during or after reset for that sequence.

Structure
REQ-019 SHALL place the FSM state encoding constants and the default SYNC_STAGES in a shared package i_rotary_encoder_pkg.
REQ-020 SHALL implement the synchronizer as sub-module sync_ff, parameterized by stage count and instantiated once per phase.

Verification
REQ-021 SHALL verify the full clockwise cycle: 01,11,10,00, one step per cycle, repeated 3 times -> three pulses with o_cnt_cw=1, and a counter goes 0->3.
REQ-022 SHALL verify the full counterclockwise cycle: 10,11,01,00, repeated 3 times -> three pulses with o_cnt_cw=0, and the counter goes 3->0.
REQ-023 SHALL verify short cycles: 01,10,00 x3 -> counter +3; then 10,01,00 x3 -> counter -3.
REQ-024 SHALL verify rejected sequences: 01,00,10,00; 00,11,00; 10,11,10,00; 01,11,01,00; 10,11,00; 01,11,00 -> no change on o_cnt or o_cnt_cw.
REQ-025 SHALL verify latency: in a single full CW cycle, o_cnt is high exactly on the 4th rising edge after 00 is applied, for one cycle.
REQ-026 SHALL verify reset: assert i_rst after 01,11 is applied, then apply 10,00 -> no pulse, and outputs are 0 during reset.

Source files
------------

// File: rtl/i_rotary_encoder_pkg.sv
// Shared definitions for the quadrature rotary encoder decoder.
// Phase pairs are written {B,A}.
package i_rotary_encoder_pkg;

    localparam int SYNC_STAGES_DEFAULT = 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CW1     = 3'd1,
        ST_CW2     = 3'd2,
        ST_CW3     = 3'd3,
        ST_CCW1    = 3'd4,
        ST_CCW2    = 3'd5,
        ST_CCW3    = 3'd6,
        ST_INVALID = 3'd7
    } state_t;

    localparam logic [1:0] PH_00 = 2'b00;
    localparam logic [1:0] PH_01 = 2'b01;
    localparam logic [1:0] PH_10 = 2'b10;
    localparam logic [1:0] PH_11 = 2'b11;

endpackage

// File: rtl/sync_ff.sv
// Multi-stage flip-flop synchronizer for one asynchronous input bit.
// Resets to 0 so a mid-rotation reset restarts decoding from phase 00.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                always_ff @(posedge i_clk) begin
                    if (i_rst) r_sync[gi] <= 1'b0;
                    else       r_sync[gi] <= i_d;
                end
            end else begin : g_next
                always_ff @(posedge i_clk) begin
                    if (i_rst) r_sync[gi] <= 1'b0;
                    else       r_sync[gi] <= r_sync[gi-1];
                end
            end
        end
    endgenerate

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/i_rotary_encoder.sv
// Quadrature rotary encoder decoder: synchronizes both phases and emits one
// registered pulse plus direction per completed detent.
module i_rotary_encoder
    import i_rotary_encoder_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_phase_a,
    input  logic i_phase_b,
    output logic o_cnt,
    output logic o_cnt_cw
);

    logic [1:0] w_raw;
    logic [1:0] w_sync;
    logic [1:0] r_ab;
    state_t     r_state;
    logic       r_cnt;
    logic       r_cnt_cw;

    assign w_raw = {i_phase_b, i_phase_a};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sync
            sync_ff #(
                .STAGES (SYNC_STAGES)
            ) u_sync (
                .i_clk (i_clk),
                .i_rst (i_rst),
                .i_d   (w_raw[gi]),
                .o_q   (w_sync[gi])
            );
        end
    endgenerate

    // r_ab retimes the synchronized pair so the FSM sees a clean registered
    // input; together with the registered outputs this sets the detent latency.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ab     <= PH_00;
            r_state  <= ST_IDLE;
            r_cnt    <= 1'b0;
            r_cnt_cw <= 1'b0;
        end else begin
            r_ab  <= w_sync;
            r_cnt <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    case (r_ab)
                        PH_01:   r_state <= ST_CW1;
                        PH_10:   r_state <= ST_CCW1;
                        PH_11:   r_state <= ST_INVALID;
                        default: r_state <= r_state;
                    endcase
                end
                ST_CW1: begin
                    case (r_ab)
                        PH_11:   r_state <= ST_CW2;
                        PH_10:   r_state <= ST_CW3;
                        PH_00:   r_state <= ST_IDLE;
                        default: r_state <= r_state;
                    endcase
                end
                ST_CW2: begin
                    case (r_ab)
                        PH_10:   r_state <= ST_CW3;
                        PH_01:   r_state <= ST_CW1;
                        PH_00:   r_state <= ST_IDLE;
                        default: r_state <= r_state;
                    endcase
                end
                ST_CW3: begin
                    case (r_ab)
                        PH_00: begin
                            r_state  <= ST_IDLE;
                            r_cnt    <= 1'b1;
                            r_cnt_cw <= 1'b1;
                        end
                        PH_11:   r_state <= ST_CW2;
                        PH_01:   r_state <= ST_INVALID;
                        default: r_state <= r_state;
                    endcase
                end
                ST_CCW1: begin
                    case (r_ab)
                        PH_11:   r_state <= ST_CCW2;
                        PH_01:   r_state <= ST_CCW3;
                        PH_00:   r_state <= ST_IDLE;
                        default: r_state <= r_state;
                    endcase
                end
                ST_CCW2: begin
                    case (r_ab)
                        PH_01:   r_state <= ST_CCW3;
                        PH_10:   r_state <= ST_CCW1;
                        PH_00:   r_state <= ST_IDLE;
                        default: r_state <= r_state;
                    endcase
                end
                ST_CCW3: begin
                    case (r_ab)
                        PH_00: begin
                            r_state  <= ST_IDLE;
                            r_cnt    <= 1'b1;
                            r_cnt_cw <= 1'b0;
                        end
                        PH_11:   r_state <= ST_CCW2;
                        PH_10:   r_state <= ST_INVALID;
                        default: r_state <= r_state;
                    endcase
                end
                ST_INVALID: begin
                    if (r_ab == PH_00) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_cnt    = r_cnt;
    assign o_cnt_cw = r_cnt_cw;

endmodule

// File: tb/tb_i_rotary_encoder.sv
// Self-checking bench: directed phase sequences plus random phase traffic,
// compared cycle by cycle against a path-based model of detent recognition.
module tb_i_rotary_encoder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ph_a = 1'b0;
    logic ph_b = 1'b0;
    logic o_cnt;
    logic o_cnt_cw;

    always #5 clk = ~clk;

    i_rotary_encoder #(
        .SYNC_STAGES (2)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_phase_a (ph_a),
        .i_phase_b (ph_b),
        .o_cnt     (o_cnt),
        .o_cnt_cw  (o_cnt_cw)
    );

    typedef struct packed {
        logic cnt;
        logic cw;
        logic clr;
    } ev_t;

    int   tests = 0;
    int   fails = 0;
    int   counter = 0;
    logic last_cnt = 1'b0;
    logic exp_cw = 1'b0;
    ev_t  q[$];

    // Model state: the last phase pair seen, the direction chosen when the
    // shaft left 00, and whether the current excursion became illegal.
    logic [1:0] m_prev = 2'b00;
    logic       m_dir_cw = 1'b0;
    logic       m_inv = 1'b0;

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Check the outputs produced by the last edge, then apply the next input.
    // An input applied after edge t is first sampled at edge t+1 and its
    // detent pulse is expected right after edge t+4.
    task automatic step(input logic [1:0] v, input logic r, input string tag);
        ev_t pe;
        ev_t e;
        ev_t clr_ev;
        @(posedge clk);
        #1;
        pe = q.pop_front();
        if (pe.clr)      exp_cw = 1'b0;
        else if (pe.cnt) exp_cw = pe.cw;
        check_bit({tag, "/cnt"}, o_cnt, pe.cnt);
        check_bit({tag, "/cw"}, o_cnt_cw, exp_cw);
        last_cnt = o_cnt;
        if (o_cnt === 1'b1) counter += (o_cnt_cw === 1'b1) ? 1 : -1;

        rst  = r;
        ph_b = v[1];
        ph_a = v[0];
        e = '0;
        if (r) begin
            clr_ev = '0;
            clr_ev.clr = 1'b1;
            foreach (q[i]) q[i] = clr_ev;
            e = clr_ev;
            m_prev = 2'b00;
            m_inv  = 1'b0;
        end else if (v != m_prev) begin
            if (m_prev == 2'b00) begin
                m_inv    = (v == 2'b11);
                m_dir_cw = (v == 2'b01);
            end else if (v == 2'b00) begin
                if (!m_inv && m_dir_cw && m_prev == 2'b10) begin
                    e.cnt = 1'b1;
                    e.cw  = 1'b1;
                end else if (!m_inv && !m_dir_cw && m_prev == 2'b01) begin
                    e.cnt = 1'b1;
                    e.cw  = 1'b0;
                end
            end else if (m_dir_cw && m_prev == 2'b10 && v == 2'b01) begin
                m_inv = 1'b1;
            end else if (!m_dir_cw && m_prev == 2'b01 && v == 2'b10) begin
                m_inv = 1'b1;
            end
            m_prev = v;
        end
        q.push_back(e);
    endtask

    task automatic seq(input logic [7:0] vals, input int n, input string tag);
        logic [7:0] tmp;
        tmp = vals;
        for (int i = n - 1; i >= 0; i--) step(tmp[2*i +: 2], 1'b0, tag);
    endtask

    task automatic settle(input string tag);
        for (int i = 0; i < 6; i++) step(2'b00, 1'b0, tag);
    endtask

    initial begin
        ev_t init_ev;
        int  start;
        int  lat;
        int  pulses;
        init_ev = '0;
        init_ev.clr = 1'b1;
        for (int i = 0; i < 4; i++) q.push_back(init_ev);

        for (int i = 0; i < 4; i++) step(2'b00, 1'b1, "reset");
        settle("idle");
        check_int("reset_counter", counter, 0);
        $display("[TB] reset done, counter=%0d", counter);

        for (int k = 0; k < 3; k++) seq({2'b01, 2'b11, 2'b10, 2'b00}, 4, "cw_full");
        settle("cw_full");
        check_int("cw_full_count", counter, 3);
        $display("[TB] cw full x3, counter=%0d", counter);

        for (int k = 0; k < 3; k++) seq({2'b10, 2'b11, 2'b01, 2'b00}, 4, "ccw_full");
        settle("ccw_full");
        check_int("ccw_full_count", counter, 0);
        $display("[TB] ccw full x3, counter=%0d", counter);

        for (int k = 0; k < 3; k++) seq({2'b00, 2'b01, 2'b10, 2'b00}, 3, "cw_short");
        settle("cw_short");
        check_int("cw_short_count", counter, 3);
        for (int k = 0; k < 3; k++) seq({2'b00, 2'b10, 2'b01, 2'b00}, 3, "ccw_short");
        settle("ccw_short");
        check_int("ccw_short_count", counter, 0);
        $display("[TB] short cycles, counter=%0d", counter);

        seq({2'b01, 2'b00, 2'b10, 2'b00}, 4, "rej1");
        seq({2'b00, 2'b00, 2'b11, 2'b00}, 3, "rej2");
        seq({2'b10, 2'b11, 2'b10, 2'b00}, 4, "rej3");
        seq({2'b01, 2'b11, 2'b01, 2'b00}, 4, "rej4");
        seq({2'b00, 2'b10, 2'b11, 2'b00}, 3, "rej5");
        seq({2'b00, 2'b01, 2'b11, 2'b00}, 3, "rej6");
        settle("rej");
        check_int("rejected_count", counter, 0);
        $display("[TB] rejected sequences, counter=%0d", counter);

        seq({2'b00, 2'b01, 2'b11, 2'b10}, 3, "latency");
        step(2'b00, 1'b0, "latency");
        lat = 0;
        pulses = 0;
        for (int i = 1; i <= 7; i++) begin
            step(2'b00, 1'b0, "latency");
            if (last_cnt === 1'b1) begin
                pulses++;
                lat = i;
            end
        end
        check_int("latency_edges", lat, 4);
        check_int("latency_pulses", pulses, 1);
        $display("[TB] latency edges=%0d pulses=%0d", lat, pulses);

        start = counter;
        seq({2'b00, 2'b00, 2'b01, 2'b11}, 2, "rst_mid");
        for (int i = 0; i < 3; i++) step(2'b11, 1'b1, "rst_hold");
        step(2'b11, 1'b0, "rst_hold");
        check_bit("rst_cnt_zero", o_cnt, 1'b0);
        check_bit("rst_cw_zero", o_cnt_cw, 1'b0);
        step(2'b10, 1'b0, "rst_after");
        step(2'b00, 1'b0, "rst_after");
        settle("rst_after");
        check_int("rst_no_pulse", counter, start);
        $display("[TB] reset mid-rotation, counter=%0d", counter);

        for (int n = 0; n < 400; n++) begin
            logic [1:0] v;
            int hold;
            v = 2'($urandom_range(0, 3));
            hold = $urandom_range(1, 3);
            for (int h = 0; h < hold; h++) step(v, ($urandom_range(0, 99) == 0), "random");
        end
        step(2'b00, 1'b0, "random");
        settle("random");
        $display("[TB] random traffic done, counter=%0d", counter);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

endmodule
